// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Holds the FSM state enum plus small digit/slice helpers.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] DIGIT_OFF  = 4'b1111;

   // Nibble k of a 16-bit value (digit 0 is rightmost).
   function automatic logic [3:0] nibble(
      input logic [15:0] v,
      input logic [1:0]  k
   );
      return v[{k, 2'b00} +: 4];
   endfunction

   // True when digit k and every digit to its left are zero.
   function automatic logic upper_zero(
      input logic [15:0] v,
      input logic [1:0]  k
   );
      return (v >> {k, 2'b00}) == 16'h0000;
   endfunction

   // Active-low one-hot select for digit k.
   function automatic logic [3:0] digit_sel(input logic [1:0] k);
      return ~(4'b0001 << k);
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load handshake and digit enables for seg7_scan_ctrl.
// Ports: iValue/iLoad/iEnMask from host, oAck back to host.
interface seg7_scan_ctrl_if;

   logic [15:0] iValue;
   logic        iLoad;
   logic [3:0]  iEnMask;
   logic        oAck;

   modport master (
      output iValue,
      output iLoad,
      output iEnMask,
      input  oAck
   );

   modport slave (
      input  iValue,
      input  iLoad,
      input  iEnMask,
      output oAck
   );

endinterface

// File: rtl/seg7_slot_timer.sv
// Slot counter (0..DIV-1) and digit index for the scan controller.
// Ports: iCLK, iRST (sync, high), iRun (0 holds cnt/idx at 0),
//   oIdx current digit, oInGap last lit clock of the slot,
//   oSlotEnd last clock of the slot, oFrameEnd slot end on digit 3.
module seg7_slot_timer
   import seg7_pkg::*;
#(
   parameter int DIV = 50000,
   parameter int GAP = 2
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iRun,
   output logic [1:0] oIdx,
   output logic       oInGap,
   output logic       oSlotEnd,
   output logic       oFrameEnd
);

   localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_AT  = CW'(DIV - GAP - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam bit            HAS_GAP = (GAP > 0);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;

   assign oIdx      = idx_q;
   assign oSlotEnd  = iRun && (cnt_q == CNT_MAX);
   // Raised on the final lit clock so the FSM lands in GAP
   // on the same edge the counter enters the blank region.
   assign oInGap    = HAS_GAP && iRun && (cnt_q == GAP_AT);
   assign oFrameEnd = oSlotEnd && (idx_q == 2'(NUM_DIGITS - 1));

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!iRun) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (oSlotEnd) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-seg scan controller: frame-aligned value
// updates, inter-digit blanking, leading-zero blanking, digit enables.
// Ports: iCLK, iRST (sync, high); bus (iValue/iLoad/iEnMask/oAck);
//   oDigit nibble, oDigitSel active-low select, oBlank, oFrame.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIV = 50000,
   parameter int GAP = 2,
   parameter bit LZB = 1'b1
) (
   input  logic                iCLK,
   input  logic                iRST,
   seg7_scan_ctrl_if.slave     bus,
   output logic [3:0]          oDigit,
   output logic [3:0]          oDigitSel,
   output logic                oBlank,
   output logic                oFrame
);

   state_e      state_q, state_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] pend_q, pend_d;
   logic        pend_v_q, pend_v_d;
   logic        ack_q, ack_d;
   logic [3:0]  digit_q, digit_d;
   logic [3:0]  sel_q, sel_d;
   logic        blank_q, blank_d;

   logic [1:0]  idx;
   logic        in_gap;
   logic        slot_end;
   logic        frame_end;
   logic        vis;

   seg7_slot_timer #(
      .DIV (DIV),
      .GAP (GAP)
   ) u_timer (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iRun      (state_q != S_IDLE),
      .oIdx      (idx),
      .oInGap    (in_gap),
      .oSlotEnd  (slot_end),
      .oFrameEnd (frame_end)
   );

   assign bus.oAck  = ack_q;
   assign oDigit    = digit_q;
   assign oDigitSel = sel_q;
   assign oBlank    = blank_q;
   assign oFrame    = frame_end;

   always_comb begin
      state_d  = state_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      ack_d    = bus.iLoad;

      // Latest load always wins the pending slot.
      if (bus.iLoad) begin
         pend_d   = bus.iValue;
         pend_v_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            // Nothing on screen yet, so no tearing risk: show now.
            if (bus.iLoad) begin
               disp_d   = bus.iValue;
               pend_v_d = 1'b0;
               state_d  = S_SHOW;
            end
         end
         S_SHOW: begin
            if (!slot_end && in_gap) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (slot_end) begin
               state_d = S_SHOW;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Commit at the frame edge; a load on this same cycle
      // becomes the pending value for the following frame.
      if (frame_end && pend_v_q) begin
         disp_d   = pend_q;
         pend_v_d = bus.iLoad;
      end
   end

   always_comb begin
      vis = bus.iEnMask[idx]
         && !(LZB && (idx != 2'd0) && upper_zero(disp_q, idx));
      digit_d = nibble(disp_q, idx);
      sel_d   = DIGIT_OFF;
      if (state_q == S_SHOW && vis) begin
         sel_d = digit_sel(idx);
      end
      blank_d = (sel_d == DIGIT_OFF);
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q  <= S_IDLE;
         disp_q   <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         ack_q    <= 1'b0;
         digit_q  <= '0;
         sel_q    <= DIGIT_OFF;
         blank_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         ack_q    <= ack_d;
         digit_q  <= digit_d;
         sel_q    <= sel_d;
         blank_q  <= blank_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIV=4, GAP=1; dut_a uses LZB=1,
// dut_b uses LZB=0 and receives identical stimulus.
module tb_seg7_scan_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seg7_scan_ctrl_if bus_a ();
   seg7_scan_ctrl_if bus_b ();

   logic [3:0] dig_a, sel_a, dig_b, sel_b;
   logic       blank_a, frame_a, blank_b, frame_b;

   seg7_scan_ctrl #(.DIV(4), .GAP(1), .LZB(1'b1)) dut_a (
      .iCLK      (clk),
      .iRST      (rst),
      .bus       (bus_a.slave),
      .oDigit    (dig_a),
      .oDigitSel (sel_a),
      .oBlank    (blank_a),
      .oFrame    (frame_a)
   );

   seg7_scan_ctrl #(.DIV(4), .GAP(1), .LZB(1'b0)) dut_b (
      .iCLK      (clk),
      .iRST      (rst),
      .bus       (bus_b.slave),
      .oDigit    (dig_b),
      .oDigitSel (sel_b),
      .oBlank    (blank_b),
      .oFrame    (frame_b)
   );

   typedef struct packed {
      logic [15:0] val;
      logic [3:0]  mask;
      logic [15:0] sel;   // {d3,d2,d1,d0} selects, LZB=1
      logic [15:0] sel0;  // same, LZB=0
   } vec_t;

   vec_t vecs [6];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] v, input logic ld);
      bus_a.iValue = v;
      bus_b.iValue = v;
      bus_a.iLoad  = ld;
      bus_b.iLoad  = ld;
   endtask

   task automatic set_mask(input logic [3:0] m);
      bus_a.iEnMask = m;
      bus_b.iEnMask = m;
   endtask

   task automatic load(input logic [15:0] v);
      drive(v, 1'b1);
      step();
      drive(16'h0, 1'b0);
      chk("ack", {15'b0, bus_a.oAck}, 16'd1);
   endtask

   task automatic wait_frame();
      int n = 0;
      while (frame_a !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("frame_seen", {15'b0, frame_a}, 16'd1);
   endtask

   // Called on the cycle whose state is digit 0, cnt 0; checks the
   // next 16 output cycles (3 lit + 1 dark per digit).
   task automatic check_seq(input logic [15:0] val,
                            input logic [15:0] sel,
                            input logic [15:0] sel0);
      for (int j = 0; j < 16; j++) begin
         int         k;
         logic [3:0] es, es0;
         step();
         k   = j / 4;
         es  = ((j % 4) != 3) ? sel[k*4 +: 4]  : 4'b1111;
         es0 = ((j % 4) != 3) ? sel0[k*4 +: 4] : 4'b1111;
         chk("sel_a", {12'b0, sel_a}, {12'b0, es});
         chk("dig_a", {12'b0, dig_a}, {12'b0, val[k*4 +: 4]});
         chk("blank_a", {15'b0, blank_a}, {15'b0, es == 4'b1111});
         chk("sel_b", {12'b0, sel_b}, {12'b0, es0});
         chk("frame", {15'b0, frame_a}, {15'b0, j == 14});
      end
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'hF, 16'h7BDE, 16'h7BDE};
      vecs[1] = '{16'h0005, 4'hF, 16'hFFFE, 16'h7BDE};
      vecs[2] = '{16'h0000, 4'hF, 16'hFFFE, 16'h7BDE};
      vecs[3] = '{16'h8888, 4'h5, 16'hFBFE, 16'hFBFE};
      vecs[4] = '{16'h0500, 4'hF, 16'hFBDE, 16'h7BDE};
      vecs[5] = '{16'hF000, 4'hE, 16'h7BDF, 16'h7BDF};

      rst = 1'b1;
      drive(16'h0, 1'b0);
      set_mask(4'hF);
      step();
      step();
      chk("rst_sel", {12'b0, sel_a}, 16'h000F);
      chk("rst_dig", {12'b0, dig_a}, 16'h0);
      chk("rst_blank", {15'b0, blank_a}, 16'd1);
      chk("rst_ack", {15'b0, bus_a.oAck}, 16'd0);
      chk("rst_frame", {15'b0, frame_a}, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("idle_dark", {12'b0, sel_a}, 16'h000F);

      // First load from idle: ack next cycle, digit 0 lit after two.
      load(16'h1234);
      chk("first_not_yet", {12'b0, sel_a}, 16'h000F);
      check_seq(16'h1234, 16'h7BDE, 16'h7BDE);

      for (int i = 0; i < 6; i++) begin
         set_mask(vecs[i].mask);
         load(vecs[i].val);
         wait_frame();
         step();
         check_seq(vecs[i].val, vecs[i].sel, vecs[i].sel0);
      end

      // Two loads inside one frame: only the last one appears.
      set_mask(4'hF);
      load(16'h1111);
      wait_frame();
      step();
      step();
      step();
      load(16'hAAAA);
      step();
      load(16'hBBBB);
      begin
         int n = 0;
         while (frame_a !== 1'b1 && n < 40) begin
            chk("no_tear", {12'b0, dig_a}, 16'h0001);
            step();
            n++;
         end
         chk("frame_seen", {15'b0, frame_a}, 16'd1);
      end
      chk("pre_commit", {12'b0, dig_a}, 16'h0001);
      step();
      chk("commit_edge", {12'b0, dig_a}, 16'h0001);
      check_seq(16'hBBBB, 16'h7BDE, 16'h7BDE);

      // Load on the commit cycle with nothing pending waits a frame.
      wait_frame();
      drive(16'h5555, 1'b1);
      step();
      drive(16'h0, 1'b0);
      chk("ack_commit", {15'b0, bus_a.oAck}, 16'd1);
      check_seq(16'hBBBB, 16'h7BDE, 16'h7BDE);
      check_seq(16'h5555, 16'h7BDE, 16'h7BDE);

      // Reset while digit 2 is being shown.
      begin
         int n = 0;
         while (sel_a !== 4'b1011 && n < 40) begin
            step();
            n++;
         end
         chk("dig2_seen", {12'b0, sel_a}, 16'h000B);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_sel", {12'b0, sel_a}, 16'h000F);
      chk("mrst_dig", {12'b0, dig_a}, 16'h0);
      chk("mrst_blank", {15'b0, blank_a}, 16'd1);
      chk("mrst_ack", {15'b0, bus_a.oAck}, 16'd0);
      chk("mrst_frame", {15'b0, frame_a}, 16'd0);
      chk("mrst_sel_b", {12'b0, sel_b}, 16'h000F);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("mrst_dark", {12'b0, sel_a}, 16'h000F);
      end
      load(16'h0042);
      step();
      chk("reload_sel", {12'b0, sel_a}, 16'h000E);
      chk("reload_dig", {12'b0, dig_a}, 16'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
